// File: rtl/lcd_bus_scheduler.sv
// Two-requester scheduler for the shared 8-bit HD44780 LCD write bus.
// Requester 0 is the init/command sequencer and requester 1 is the
// character-write instruction. Each accepted byte becomes one write cycle:
// setup, E pulse, hold, then the command execution wait. Done is pulsed to
// the requester that owns the transfer.
//
// Handshake: a requester presents rs/data with reqN_valid and must hold them
// stable until the cycle in which reqN_valid && reqN_ready is seen at a
// rising clock edge. That edge is the accept. reqN_ready is combinational,
// is only high in IDLE, and is only ever high for the granted requester.
// Dropping valid before the accept withdraws the request with no side effect.
module lcd_bus_scheduler #(
  parameter int T_SETUP     = 2,
  parameter int T_PULSE     = 25,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  output logic       req0_done,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       req1_done,
  output logic       busy,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_EXEC  = 3'd4
  } state_t;

  // Counter reload values: each phase counts from (length - 1) down to 0.
  localparam logic [CNT_W-1:0] LD_SETUP     = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE     = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD      = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC      = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC_LONG = CNT_W'(T_EXEC_LONG - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_owner_q;
  logic             owner_q;
  logic             lcd_en_q;
  logic             rs_q;
  logic [7:0]       data_q;

  logic             idle;
  logic             grant;
  logic             accept;
  logic             sel_rs;
  logic [7:0]       sel_data;
  logic             long_cmd;
  logic             cnt_zero;
  logic             done;

  assign idle     = (state_q == S_IDLE);
  assign cnt_zero = (cnt_q == '0);

  // Round-robin grant: a lone requester wins; on a tie the one that did not
  // own the previous transfer wins.
  always_comb begin
    grant = ~last_owner_q;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = idle && !grant;
  assign req1_ready = idle && grant;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign sel_rs     = grant ? req1_rs : req0_rs;
  assign sel_data   = grant ? req1_data : req0_data;

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign long_cmd = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

  // Next-state and counter reload for the write-cycle phases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = LD_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_PULSE;
          cnt_d   = LD_PULSE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_zero) begin
          state_d = S_HOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          state_d = S_EXEC;
          cnt_d   = long_cmd ? LD_EXEC_LONG : LD_EXEC;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EXEC: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, phase counter and registered E strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lcd_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lcd_en_q <= (state_d == S_PULSE);
    end
  end

  // Latch the granted byte and owner on accept; the pins follow from the
  // next cycle and keep their value while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      rs_q         <= 1'b0;
      data_q       <= 8'h00;
    end else if (accept) begin
      last_owner_q <= grant;
      owner_q      <= grant;
      rs_q         <= sel_rs;
      data_q       <= sel_data;
    end
  end

  assign done      = (state_q == S_EXEC) && cnt_zero;
  assign req0_done = done && !owner_q;
  assign req1_done = done && owner_q;
  assign busy      = !idle;
  assign lcd_en    = lcd_en_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_data  = data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Bench for lcd_bus_scheduler with short timing parameters. A transaction
// level model tracks each accepted byte by its cycle offset from the accept
// and checks every DUT output every cycle; directed scenarios add literal
// timing expectations.
module tb_lcd_bus_scheduler;

  localparam int S  = 2;
  localparam int P  = 4;
  localparam int H  = 2;
  localparam int E  = 10;
  localparam int EL = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic       req0_rs = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req0_done;
  logic       req1_valid = 1'b0;
  logic       req1_rs = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic       req1_done;
  logic       busy;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;
  logic [2:0] dbg_state;

  lcd_bus_scheduler #(
    .T_SETUP(S), .T_PULSE(P), .T_HOLD(H), .T_EXEC(E), .T_EXEC_LONG(EL), .CNT_W(17)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data),
    .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data),
    .req1_ready(req1_ready), .req1_done(req1_done),
    .busy(busy), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  bit         m_active = 1'b0;
  int         m_k = 0;
  int         m_total = 0;
  bit         m_owner = 1'b0;
  bit         m_last = 1'b1;
  logic       m_rs = 1'b0;
  logic [7:0] m_data = 8'h00;

  // DUT-observed events, used by the literal timing checks.
  int         dut_acc_q[$];
  logic [0:0] dut_own_q[$];
  int         dut_done_q[$];

  function automatic int exec_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'd1 && d <= 8'd3) ? EL : E;
  endfunction

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    bit g;
    chk("lcd_rw", lcd_rw, 1'b0);
    if (req0_valid && req0_ready) begin dut_acc_q.push_back(cyc); dut_own_q.push_back(1'b0); end
    if (req1_valid && req1_ready) begin dut_acc_q.push_back(cyc); dut_own_q.push_back(1'b1); end
    if (req0_done || req1_done) dut_done_q.push_back(cyc);
    if (reset) begin
      m_active = 1'b0;
      m_last   = 1'b1;
      m_rs     = 1'b0;
      m_data   = 8'h00;
      chk("rst_busy", busy, 1'b0);
      chk("rst_en", lcd_en, 1'b0);
      chk("rst_rs", lcd_rs, 1'b0);
      chk("rst_data", lcd_data, 8'h00);
      chk("rst_done0", req0_done, 1'b0);
      chk("rst_done1", req1_done, 1'b0);
    end else begin
      g = (req0_valid && req1_valid) ? !m_last : req1_valid;
      if (m_active) begin
        chk("busy", busy, 1'b1);
        chk("lcd_en", lcd_en, (m_k > S && m_k <= S + P));
        chk("done0", req0_done, (m_k == m_total && !m_owner));
        chk("done1", req1_done, (m_k == m_total && m_owner));
        chk("ready0_busy", req0_ready, 1'b0);
        chk("ready1_busy", req1_ready, 1'b0);
      end else begin
        chk("busy", busy, 1'b0);
        chk("lcd_en", lcd_en, 1'b0);
        chk("done0", req0_done, 1'b0);
        chk("done1", req1_done, 1'b0);
        if (req0_valid || req1_valid) begin
          chk("ready0", req0_ready, !g);
          chk("ready1", req1_ready, g);
        end
      end
      chk("lcd_rs", lcd_rs, m_rs);
      chk("lcd_data", lcd_data, m_data);
      if (m_active) begin
        if (m_k == m_total) m_active = 1'b0;
        else m_k++;
      end else if (req0_valid || req1_valid) begin
        m_active = 1'b1;
        m_k      = 1;
        m_owner  = g;
        m_last   = g;
        m_rs     = g ? req1_rs : req0_rs;
        m_data   = g ? req1_data : req0_data;
        m_total  = S + P + H + exec_len(m_rs, m_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit who, input logic v, input logic rs, input logic [7:0] d);
    if (who) begin req1_valid = v; req1_rs = rs; req1_data = d; end
    else begin req0_valid = v; req0_rs = rs; req0_data = d; end
  endtask

  task automatic wait_accept(input bit who, input string name, output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (who ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_accept: no accept within 300 cycles, expected one", name);
    end
  endtask

  task automatic wait_done(input bit who, input string name, output int c, output int rise);
    c = -1;
    rise = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (lcd_en && rise < 0) rise = cyc;
      if (who ? req1_done : req0_done) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_done: no done within 300 cycles, expected one", name);
    end
  endtask

  // One full transfer with literal timing checks relative to the accept.
  task automatic xfer(input bit who, input logic rs, input logic [7:0] d,
                      input int exp_off, input string name);
    int acc, dn, rise;
    @(posedge clk); #1;
    drive(who, 1'b1, rs, d);
    wait_accept(who, name, acc);
    @(posedge clk); #1;
    drive(who, 1'b0, rs, d);
    if (acc < 0) return;
    @(negedge clk);
    chk({name, "_pin_data"}, lcd_data, d);
    chk({name, "_pin_rs"}, lcd_rs, rs);
    wait_done(who, name, dn, rise);
    if (dn < 0) return;
    chk({name, "_done_off"}, dn - acc, exp_off);
    chk({name, "_en_rise_off"}, rise - acc, S + 1);
    @(negedge clk);
    chk({name, "_busy_after"}, busy, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int acc, dn, rise, base, dbase;
    logic [0:0] exp_q[$];

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("por_busy", busy, 1'b0);
    chk("por_en", lcd_en, 1'b0);
    chk("por_data", lcd_data, 8'h00);

    // Character write, then short and long commands.
    xfer(1'b1, 1'b1, 8'h41, 18, "char41");
    xfer(1'b0, 1'b0, 8'h01, 58, "cmd01");
    xfer(1'b0, 1'b0, 8'h02, 58, "cmd02");
    xfer(1'b0, 1'b0, 8'h03, 58, "cmd03");
    xfer(1'b0, 1'b0, 8'h38, 18, "cmd38");
    xfer(1'b1, 1'b0, 8'h01, 58, "r1cmd01");

    // Both requesters valid continuously: grants alternate 0,1,0,1.
    base  = dut_own_q.size();
    dbase = dut_done_q.size();
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 8'h30);
    drive(1'b1, 1'b1, 1'b1, 8'h31);
    for (int i = 0; i < 300 && dut_own_q.size() < base + 4; i++) @(negedge clk);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 8'h30);
    drive(1'b1, 1'b0, 1'b1, 8'h31);
    for (int i = 0; i < 300 && dut_done_q.size() < dbase + 4; i++) @(negedge clk);
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    if (dut_own_q.size() < base + 4 || dut_done_q.size() < dbase + 4) begin
      n_cmp++; n_fail++;
      $display("FAIL rr_count: got %0d accepts %0d dones, expected 4 each",
               dut_own_q.size() - base, dut_done_q.size() - dbase);
    end else begin
      for (int i = 0; i < 4; i++) chk($sformatf("rr_owner%0d", i), dut_own_q[base + i], exp_q[i]);
      for (int i = 0; i < 3; i++)
        chk($sformatf("rr_gap%0d", i), dut_acc_q[base + i + 1] - dut_done_q[dbase + i], 1);
    end

    // req0 changes its byte while waiting behind a req1 transfer.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 8'h61);
    wait_accept(1'b1, "wait61", acc);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 8'h61);
    drive(1'b0, 1'b1, 1'b1, 8'h10);
    repeat (5) @(posedge clk);
    #1 drive(1'b0, 1'b1, 1'b1, 8'h20);
    wait_accept(1'b0, "late20", acc);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 8'h20);
    @(negedge clk);
    chk("late20_pin_data", lcd_data, 8'h20);
    wait_done(1'b0, "late20", dn, rise);
    if (acc >= 0 && dn >= 0) chk("late20_done_off", dn - acc, 18);

    // Reset asserted while E is high.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 8'h55);
    wait_accept(1'b1, "rst55", acc);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 8'h55);
    rise = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lcd_en) begin rise = cyc; break; end
    end
    chk("rst55_en_seen", (rise >= 0), 1'b1);
    dbase = dut_done_q.size();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_en", lcd_en, 1'b0);
    chk("midrst_data", lcd_data, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", dut_done_q.size() - dbase, 0);
    xfer(1'b1, 1'b1, 8'h46, 18, "after_rst");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
